// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the multiply sequencer state encoding.
// Reused by the ALU and every controller that drives it.
package alu_pkg;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_PASS = 3'd2;
  localparam logic [2:0] ALU_ZER  = 3'd3;
  localparam logic [2:0] ALU_DECA = 3'd4;
  localparam logic [2:0] ALU_MUL2 = 3'd5;
  localparam logic [2:0] ALU_DIV2 = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TEST = 3'd1,
    ST_ADD  = 3'd2,
    ST_SHL  = 3'd3,
    ST_SHR  = 3'd4,
    ST_DONE = 3'd5
  } mul_state_e;
endpackage

// File: rtl/alu.sv
// Shared combinational 16-bit ALU: C_bus = f(op, A_bus, B_bus), Z flags C_bus == 0.
// Unary operations (PASS, MUL2, DIV2) act on B_bus; DECA acts on A_bus.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] c_o,
  output logic             z_o
);
  always_comb begin
    c_o = '0;
    case (op_i)
      ALU_ADD:  c_o = a_i + b_i;
      ALU_SUB:  c_o = a_i - b_i;
      ALU_PASS: c_o = b_i;
      ALU_ZER:  c_o = '0;
      ALU_DECA: c_o = a_i - 1'b1;
      ALU_MUL2: c_o = {b_i[WIDTH-2:0], 1'b0};
      ALU_DIV2: c_o = {1'b0, b_i[WIDTH-1:1]};
      default:  c_o = '0;
    endcase
  end

  assign z_o = (c_o == '0);
endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier (low 16 bits of a 16x16 product) that borrows the shared ALU.
// FSM and working registers live in one block; ALU drive is a Moore decode of state.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_z
);
  mul_state_e       state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mcand_q  <= a_in;
            mplier_q <= b_in;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_TEST;
          end
        end
        ST_TEST: begin
          // Result is loaded on entry to DONE so it is valid alongside the done pulse.
          if (alu_z) begin
            result_q <= acc_q;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else if (mplier_q[0]) begin
            state_q <= ST_ADD;
          end else begin
            state_q <= ST_SHL;
          end
        end
        ST_ADD: begin
          acc_q <= alu_c;
          if (alu_c < acc_q) ovf_q <= 1'b1;
          state_q <= ST_SHL;
        end
        ST_SHL: begin
          // A multiplicand bit falling off the top matters only if a later add would use it.
          mcand_q <= alu_c;
          if (mcand_q[WIDTH-1] && (mplier_q[WIDTH-1:1] != '0)) ovf_q <= 1'b1;
          state_q <= ST_SHR;
        end
        ST_SHR: begin
          mplier_q <= alu_c;
          state_q  <= ST_TEST;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    alu_op = ALU_ZER;
    alu_a  = '0;
    alu_b  = '0;
    case (state_q)
      ST_TEST: begin
        alu_op = ALU_PASS;
        alu_b  = mplier_q;
      end
      ST_ADD: begin
        alu_op = ALU_ADD;
        alu_a  = acc_q;
        alu_b  = mcand_q;
      end
      ST_SHL: begin
        alu_op = ALU_MUL2;
        alu_b  = mcand_q;
      end
      ST_SHR: begin
        alu_op = ALU_DIV2;
        alu_b  = mplier_q;
      end
      default: begin
        alu_op = ALU_ZER;
      end
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer driving the real ALU; results, overflow and
// latency are checked against an arithmetic reference model.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;
  logic [2:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_c;
  logic        alu_z;

  int n_checks = 0;
  int n_fail   = 0;
  int bad_ops  = 0;
  logic [2:0] trace[$];

  alu_mul_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result), .ovf(ovf),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_z(alu_z)
  );

  alu #(.WIDTH(16)) u_alu (
    .op_i(alu_op), .a_i(alu_a), .b_i(alu_b), .c_o(alu_c), .z_o(alu_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: cycles = 2 + 3*(position of top set bit + 1) + popcount.
  function automatic int model_latency(input logic [15:0] b);
    int n = 0;
    int k = 0;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) begin
        n = i + 1;
        k++;
      end
    end
    return 2 + 3 * n + k;
  endfunction

  // Starts a multiply and waits for done; optionally pokes start again mid-run.
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input int poke_at,
                        output logic [15:0] res, output logic ov, output int cyc);
    trace.delete();
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (poke_at != 0 && cyc == poke_at) begin
        start = 1'b1;
        a_in  = ~a;
        b_in  = b ^ 16'h0005;
      end else if (poke_at != 0 && cyc == poke_at + 1) begin
        start = 1'b0;
      end
      if (alu_op == 3'd4 || alu_op == 3'd7) bad_ops++;
      if (busy && !done) trace.push_back(alu_op);
      if (done) break;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 32'd0, 32'd1);
    res = result;
    ov  = ovf;
  endtask

  task automatic run_case(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int poke_at);
    logic [15:0] res;
    logic        ov;
    int          cyc;
    logic [31:0] prod;
    prod = {16'd0, a} * {16'd0, b};
    do_mul(a, b, poke_at, res, ov, cyc);
    check({tag, "_result"}, {16'd0, res}, {16'd0, prod[15:0]});
    check({tag, "_ovf"}, {31'd0, ov}, {31'd0, (prod[31:16] != 16'd0)});
    check({tag, "_latency"}, cyc, model_latency(b));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_held"}, {16'd0, result}, {16'd0, prod[15:0]});
  endtask

  logic [2:0] exp_tr[9];

  initial begin
    exp_tr = '{ALU_PASS, ALU_ADD, ALU_MUL2, ALU_DIV2,
               ALU_PASS, ALU_ADD, ALU_MUL2, ALU_DIV2, ALU_PASS};
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_alu_op", {29'd0, alu_op}, 32'd3);
    check("rst_alu_a", {16'd0, alu_a}, 32'd0);
    check("rst_alu_b", {16'd0, alu_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_case("m7x3", 16'd7, 16'd3, 0);
    check("m7x3_trace_len", trace.size(), 32'd9);
    for (int i = 0; i < 9; i++)
      if (i < trace.size()) check($sformatf("m7x3_trace%0d", i), {29'd0, trace[i]}, {29'd0, exp_tr[i]});

    run_case("m1234x0", 16'd1234, 16'd0, 0);
    check("m1234x0_trace_len", trace.size(), 32'd1);
    if (trace.size() > 0) check("m1234x0_pass", {29'd0, trace[0]}, {29'd0, ALU_PASS});

    run_case("m100x100", 16'h0100, 16'h0100, 0);
    run_case("mffffx1", 16'hFFFF, 16'd1, 0);
    run_case("a0", 16'd0, 16'hA5A5, 0);
    run_case("mffffxffff", 16'hFFFF, 16'hFFFF, 0);

    run_case("poke", 16'd7, 16'd3, 3);
    run_case("after_poke", 16'd9, 16'd9, 0);

    // Reset mid-operation, in the SHL cycle of 5x5.
    @(negedge clk);
    a_in  = 16'd5;
    b_in  = 16'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_shl", {29'd0, alu_op}, {29'd0, ALU_MUL2});
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_ovf", {31'd0, ovf}, 32'd0);
    check("midrst_result", {16'd0, result}, 32'd0);
    check("midrst_alu_op", {29'd0, alu_op}, {29'd0, ALU_ZER});
    @(negedge clk);
    rst = 1'b0;
    run_case("m5x5", 16'd5, 16'd5, 0);

    for (int t = 0; t < 20; t++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (t % 3 == 0) rb = rb & 16'h00FF;
      if (t % 5 == 0) ra = ra & 16'h00FF;
      run_case($sformatf("rnd%0d", t), ra, rb, 0);
    end

    check("illegal_alu_ops", bad_ops, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes an unsigned 16x16 multiply (low 16 bits of the product) by sequencing the shared 16-bit ALU.
- Uses the ALU's ADD, PASS, MUL2 and DIV2 operations and its Z flag in a shift-add loop.
- Sits beside the ALU in the datapath and owns the ALU's operator, A_bus and B_bus inputs while busy.
- Provides a start/done handshake to the instruction control unit.

Parameters:
- WIDTH, 16, data width; must equal the ALU bus width. Only 16 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request a multiply. Sampled only in IDLE.
- a_in  in  16  multiplicand, latched on an accepted start.
- b_in  in  16  multiplier, latched on an accepted start.
- busy  out  1  high from the cycle after start is accepted through DONE.
- done  out  1  one-cycle pulse in DONE.
- result  out  16  product low 16 bits; held until the next accepted start.
- ovf  out  1  sticky: the true product exceeded 16 bits. Valid with done, held with result.
- alu_op  out  3  ALU operator select.
- alu_a  out  16  drives ALU A_bus.
- alu_b  out  16  drives ALU B_bus.
- alu_c  in  16  ALU C_bus.
- alu_z  in  1  ALU Z flag.

Behaviour:
- Reset is asynchronous and active-high on rst. Clock is clk.
- Reset values: state=IDLE; acc, mcand, mplier, result = 0; ovf=0; busy=0; done=0; alu_op=ZER (3'd3); alu_a=alu_b=0.
- The ALU is combinational, so alu_c and alu_z are sampled at the clock edge that ends the state driving alu_op.
- ALU drive outputs are decoded from state and internal registers (Moore). No register stage is added on the ALU path.
- IDLE: drive op=ZER, a=b=0. On start=1, latch mcand<=a_in and mplier<=b_in, clear acc and ovf, then go to TEST.
- TEST: drive op=PASS, b=mplier.
  - alu_z=1: go to DONE.
  - alu_z=0 and mplier[0]=1: go to ADD.
  - alu_z=0 and mplier[0]=0: go to SHL.
- ADD: drive op=ADD, a=acc, b=mcand. acc<=alu_c. If alu_c < acc (unsigned carry), set ovf. Go to SHL.
- SHL: drive op=MUL2, b=mcand. mcand<=alu_c. If mcand[15]=1 and mplier[15:1]!=0, set ovf. Go to SHR.
- SHR: drive op=DIV2, b=mplier. mplier<=alu_c. Go to TEST.
- DONE: done=1, result<=acc. Go to IDLE.
- busy=1 in TEST, ADD, SHL, SHR and DONE.
- Latency from the start edge to done=1:
  - 2 + 3*n + k cycles, where n = (index of b_in's MSB set)+1 and k = popcount(b_in).
  - b_in=0 gives 2 cycles. The maximum, b_in=0xFFFF, gives 66 cycles.
- Early exit: the loop ends once the multiplier shifts to zero, so a_in=0 still iterates over b_in's bits and returns 0.
- start while busy is ignored, with no queuing.
- start held high in DONE is not seen. It is accepted on the following IDLE cycle.
- Reset asserted mid-operation returns to IDLE immediately and clears result and ovf. No done pulse is issued.
- alu_op never takes values 3'd7 or 3'd4 (DECA unused).

Decomposition:
- Shared package (alu_pkg) holds:
  - ALU opcode constants ADD=0, SUB=1, PASS=2, ZER=3, DECA=4, MUL2=5, DIV2=6, for reuse by the ALU and all controllers.
  - The state encoding IDLE, TEST, ADD, SHL, SHR, DONE.
- No sub-module. The FSM and the three working registers form one block.
- The testbench instantiates the real alu beside this block.

Test Plan:
- a_in=7, b_in=3, pulse start → done after 10 cycles, result=21, ovf=0. The alu_op trace is PASS, ADD, MUL2, DIV2, PASS, ADD, MUL2, DIV2, PASS.
- a_in=1234, b_in=0 → done 2 cycles after start, result=0, ovf=0, one PASS issued.
- a_in=0x0100, b_in=0x0100 → result=0x0000, ovf=1. a_in=0xFFFF, b_in=1 → result=0xFFFF, ovf=0, done after 6 cycles.
- a_in=0xFFFF, b_in=0xFFFF → done after exactly 66 cycles, result=0x0001, ovf=1.
- start pulsed again during busy with different operands → ignored. The first result is unchanged, and a later start in IDLE is accepted.
- rst asserted in the SHL cycle of a 5x5 multiply → busy, done, ovf and result go to 0 without a clock edge, alu_op=ZER. A fresh 5x5 multiply then gives 25.
